// File: rtl/execution_stage_muldiv_pkg.sv
// execution_stage_muldiv_pkg: shared op and state encodings for the iterative multiply/divide unit.
package execution_stage_muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} muldiv_state_t;
endpackage

// File: rtl/execution_stage_muldiv_iter_core.sv
// muldiv_iter_core: one radix-2 shift-add / restoring shift-subtract step per clock on unsigned magnitudes.
// hi holds the product high half or partial remainder; lo holds the multiplier or dividend/quotient.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic [XLEN-1:0] hi_n,
  output logic [XLEN-1:0] lo_n
);
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [XLEN:0]   sum, rem_sh, diff;
  always_comb begin
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh = {hi_q, lo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, b_q};
    // partial remainder stays below the divisor, so a non-negative diff always fits in XLEN bits
    hi_n   = is_div ? (diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
    lo_n   = is_div ? {lo_q[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo_q[XLEN-1:1]};
    hi_d   = load ? '0 : step ? hi_n : hi_q;
    lo_d   = load ? a_in : step ? lo_n : lo_q;
    b_d    = load ? b_in : b_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q  <= b_d;
    end
  end
endmodule

// File: rtl/execution_stage_muldiv.sv
// execution_stage_muldiv: multi-cycle RV32M/RV64M multiply/divide unit with valid/ready handshakes and flush.
// MULDIV_FAST_MUL_EN: multiplies use a combinational multiplier and complete on the accept edge.
module execution_stage_muldiv
  import execution_stage_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  data1,
  input  logic [XLEN-1:0]  data2,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             div_by_zero,
  output logic             overflow_flag
);
  localparam int CW = $clog2(XLEN);
  muldiv_state_t    state_q, state_d;
  muldiv_op_t       op_q, op_d, op_i;
  logic [CW-1:0]    count_q, count_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             neg_q, neg_d, dbz_q, dbz_d, ovf_q, ovf_d;
  logic             sa, sb, is_dbz, is_ovf, fast_mul;
  logic [XLEN-1:0]  a_mag, b_mag, hi_n, lo_n, q_s, r_s, fix;
  logic [2*XLEN-1:0] prod_s, fast_p;
`ifdef MULDIV_FAST_MUL_EN
  assign fast_p   = {{XLEN{sa}}, data1} * {{XLEN{sb}}, data2};
  assign fast_mul = !op[2];
`else
  assign fast_p   = '0;
  assign fast_mul = 1'b0;
`endif
  assign op_i          = muldiv_op_t'(op);
  assign in_ready      = state_q == S_IDLE && !flush;
  assign out_valid     = state_q == S_DONE;
  assign result        = result_q;
  assign tag_out       = tag_q;
  assign div_by_zero   = dbz_q;
  assign overflow_flag = ovf_q;
  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (in_valid && in_ready),
    .step   (state_q == S_CALC && !flush),
    .is_div (op_q >= OP_DIV),
    .a_in   (a_mag),
    .b_in   (b_mag),
    .hi_n   (hi_n),
    .lo_n   (lo_n)
  );
  always_comb begin
    sa      = data1[XLEN-1] && (op_i inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    sb      = data2[XLEN-1] && (op_i inside {OP_MULH, OP_DIV, OP_REM});
    a_mag   = sa ? -data1 : data1;
    b_mag   = sb ? -data2 : data2;
    is_dbz  = op[2] && data2 == '0;
    is_ovf  = (op_i == OP_DIV || op_i == OP_REM) && data1 == {1'b1, {(XLEN-1){1'b0}}} && &data2;
    prod_s  = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    q_s     = neg_q ? -lo_n : lo_n;
    r_s     = neg_q ? -hi_n : hi_n;
    fix     = op_q == OP_MUL ? prod_s[XLEN-1:0] : op_q < OP_DIV ? prod_s[2*XLEN-1:XLEN] :
              (op_q == OP_REM || op_q == OP_REMU) ? r_s : q_s;
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    tag_d    = tag_q;
    result_d = result_q;
    neg_d    = neg_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    if (flush) state_d = S_IDLE;
    else case (state_q)
      S_IDLE: if (in_valid) begin
        op_d     = op_i;
        tag_d    = tag_in;
        neg_d    = op_i == OP_REM ? sa : sa ^ sb;
        dbz_d    = is_dbz;
        ovf_d    = is_ovf;
        count_d  = CW'(XLEN-1);
        state_d  = (is_dbz || is_ovf || fast_mul) ? S_DONE : S_CALC;
        result_d = is_dbz ? (op[1] ? data1 : '1) : is_ovf ? (op[1] ? '0 : data1) :
                   fast_mul ? (op_i == OP_MUL ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN]) : result_q;
      end
      S_CALC: begin
        count_d = count_q - CW'(1);
        if (count_q == '0) begin
          state_d  = S_DONE;
          result_d = fix;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      count_q  <= '0;
      tag_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      count_q  <= count_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule
